// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// funct3 encodings, FSM states and access sizing.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    logic [3:0] s;
    unique case (f3)
      F3_B, F3_BU: s = 4'd1;
      F3_H, F3_HU: s = 4'd2;
      F3_W, F3_WU: s = 4'd4;
      F3_D:        s = 4'd8;
      default:     s = 4'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the loaded bytes from an 8-byte window
// and sign- or zero-extends them to 64 bits.
module load_extender
  import data_mem_pkg::*;
(
  input  logic [63:0] window,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] sh;

  assign sh = window >> {offset, 3'b000};

  always_comb begin
    result = '0;
    unique case (funct3)
      F3_B:    result = {{56{sh[7]}}, sh[7:0]};
      F3_H:    result = {{48{sh[15]}}, sh[15:0]};
      F3_W:    result = {{32{sh[31]}}, sh[31:0]};
      F3_D:    result = sh;
      F3_BU:   result = {56'd0, sh[7:0]};
      F3_HU:   result = {48'd0, sh[15:0]};
      F3_WU:   result = {32'd0, sh[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed data memory with valid/ready
// request and response channels, one request in flight.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t state, state_next;
  logic [CW-1:0] cnt;

  logic [63:0] addr_q, wdata_q;
  logic        write_q;
  logic [2:0]  f3_q;

  logic [7:0] mem [DEPTH_BYTES];

  logic        accept, access;
  logic [63:0] a_addr, a_wdata, wsh;
  logic        a_write;
  logic [2:0]  a_f3;
  logic [3:0]  size;
  logic [7:0]  mask;
  logic [AW-1:0] base;
  logic        bad_f3, misal, oob, err;
  logic [63:0] window, ext;

  logic [63:0] rdata_q;
  logic        err_q;

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With LATENCY 1 the access uses the live request, not the capture.
  assign access = !reset &&
    ((accept && LATENCY == 1) || (state == WAIT && cnt == '0));

  assign a_addr  = (state == IDLE) ? req_addr   : addr_q;
  assign a_write = (state == IDLE) ? req_write  : write_q;
  assign a_f3    = (state == IDLE) ? req_funct3 : f3_q;
  assign a_wdata = (state == IDLE) ? req_wdata  : wdata_q;

  assign size = size_of(a_f3);
  assign base = a_addr[AW-1:0] & ~AW'(7);
  assign mask = 8'(((16'd1 << size) - 16'd1) << a_addr[2:0]);
  assign wsh  = a_wdata << {a_addr[2:0], 3'b000};

  assign bad_f3 = a_write ? a_f3[2] : (a_f3 == 3'b111);
  assign misal  = |(a_addr[3:0] & (size - 4'd1));
  assign oob    = (|a_addr[63:AW]) ||
    (({1'b0, a_addr[AW-1:0]} + (AW+1)'(size)) >
     (AW+1)'(DEPTH_BYTES));
  assign err    = bad_f3 | misal | oob;

  always_comb begin
    window = '0;
    for (int i = 0; i < 8; i++)
      window[8*i +: 8] = mem[base + AW'(i)];
  end

  load_extender u_ext (
    .window (window),
    .offset (a_addr[2:0]),
    .funct3 (a_f3),
    .result (ext)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid)
              state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= CNT_INIT;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (access) begin
        err_q   <= err;
        rdata_q <= (err || a_write) ? '0 : ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      write_q <= req_write;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
  end

  // Storage survives reset; only the in-flight access is gated by it.
  always_ff @(posedge clk) begin
    if (access && a_write && !err)
      for (int i = 0; i < 8; i++)
        if (mask[i]) mem[base + AW'(i)] <= wsh[8*i +: 8];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized check of data_mem_responder
// against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [DEPTH];
  logic [63:0] last_rdata;
  logic        last_err;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic w,
                                input logic [2:0] f3,
                                input logic [63:0] wd,
                                output logic [63:0] rd,
                                output logic e);
    int sz;
    sz = 1 << f3[1:0];
    e = 0;
    rd = '0;
    if (w && f3 > 3) e = 1;
    if (!w && f3 == 7) e = 1;
    if (a % sz != 0) e = 1;
    if (a >= DEPTH || a + sz > DEPTH) e = 1;
    if (e) return;
    if (w) begin
      for (int i = 0; i < sz; i++)
        ref_mem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < sz; i++)
        rd[8*i +: 8] = ref_mem[int'(a) + i];
      if (f3 < 4 && sz < 8 && rd[8*sz-1])
        rd = rd | (~64'd0 << (8*sz));
    end
  endfunction

  task automatic send(input logic [63:0] a, input logic w,
                      input logic [2:0] f3, input logic [63:0] wd);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("req_ready_timeout", {63'd0, req_ready}, 64'd1);
    req_valid = 1;
    req_addr = a;
    req_write = w;
    req_funct3 = f3;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_rsp(output int k);
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      k++;
      @(negedge clk);
    end
  endtask

  task automatic xact(input string tag, input logic [63:0] a,
                      input logic w, input logic [2:0] f3,
                      input logic [63:0] wd, input int hold);
    logic [63:0] er;
    logic ee;
    int k;
    model(a, w, f3, wd, er, ee);
    send(a, w, f3, wd);
    wait_rsp(k);
    chk({tag, " latency"}, 64'(k), 64'(LAT));
    chk({tag, " rdata"}, rsp_rdata, er);
    chk({tag, " err"}, {63'd0, rsp_err}, {63'd0, ee});
    last_rdata = rsp_rdata;
    last_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " held"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, " held rdata"}, rsp_rdata, er);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  initial begin
    logic [63:0] er, r0;
    logic ee, e0;
    int k;

    reset = 1;
    req_valid = 0;
    req_addr = '0;
    req_write = 0;
    req_funct3 = '0;
    req_wdata = '0;
    rsp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("reset req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk("reset rsp_err", {63'd0, rsp_err}, 64'd0);

    for (int a = 0; a < DEPTH; a += 8)
      xact("init", 64'(a), 1, 3'b011, {$urandom, $urandom}, 0);

    xact("sd8", 64'd8, 1, 3'b011, 64'h1122334455667788, 0);
    xact("ld8", 64'd8, 0, 3'b011, 64'd0, 1);
    chk("ld8 const", last_rdata, 64'h1122334455667788);
    xact("lb8", 64'd8, 0, 3'b000, 64'd0, 0);
    chk("lb8 const", last_rdata, 64'hFFFFFFFFFFFFFF88);
    xact("lbu8", 64'd8, 0, 3'b100, 64'd0, 0);
    chk("lbu8 const", last_rdata, 64'h88);
    xact("lh10", 64'd10, 0, 3'b001, 64'd0, 0);
    chk("lh10 const", last_rdata, 64'h5566);
    xact("lw12", 64'd12, 0, 3'b010, 64'd0, 0);
    chk("lw12 const", last_rdata, 64'h11223344);
    xact("lhu14", 64'd14, 0, 3'b101, 64'd0, 0);
    chk("lhu14 const", last_rdata, 64'h1122);

    xact("lw6 misaligned", 64'd6, 0, 3'b010, 64'd0, 0);
    chk("lw6 err const", {63'd0, last_err}, 64'd1);
    xact("sw3 misaligned", 64'd3, 1, 3'b010, 64'hDEADBEEF, 0);
    chk("sw3 err const", {63'd0, last_err}, 64'd1);
    xact("ld0 after bad sw", 64'd0, 0, 3'b011, 64'd0, 0);

    xact("lw252", 64'd252, 0, 3'b010, 64'd0, 0);
    chk("lw252 err const", {63'd0, last_err}, 64'd0);
    xact("ld256", 64'd256, 0, 3'b011, 64'd0, 0);
    chk("ld256 err const", {63'd0, last_err}, 64'd1);
    xact("sb max", ~64'd0, 1, 3'b000, 64'h5A, 0);
    chk("sb max err const", {63'd0, last_err}, 64'd1);
    xact("load f3=7", 64'd0, 0, 3'b111, 64'd0, 0);
    xact("store f3=4", 64'd0, 1, 3'b100, 64'h77, 0);

    // Stall the response and poke a request that must be ignored.
    model(64'd8, 0, 3'b011, 64'd0, er, ee);
    send(64'd8, 0, 3'b011, 64'd0);
    wait_rsp(k);
    chk("stall latency", 64'(k), 64'(LAT));
    r0 = rsp_rdata;
    e0 = rsp_err;
    chk("stall rdata", r0, er);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2);
      req_addr = 64'd0;
      req_write = 1;
      req_funct3 = 3'b011;
      req_wdata = 64'hCAFEF00DCAFEF00D;
      chk("stall rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("stall rdata stable", rsp_rdata, r0);
      chk("stall err stable", {63'd0, rsp_err}, {63'd0, e0});
      chk("stall req_ready", {63'd0, req_ready}, 64'd0);
    end
    @(negedge clk);
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    chk("post hs rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("post hs req_ready", {63'd0, req_ready}, 64'd1);
    xact("ld0 after ignored sd", 64'd0, 0, 3'b011, 64'd0, 0);

    // Reset while a store waits: the store must vanish.
    send(64'd16, 1, 3'b011, 64'hAA);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk("midreset rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midreset req_ready", {63'd0, req_ready}, 64'd1);
    xact("ld16 after reset", 64'd16, 0, 3'b011, 64'd0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [63:0] a;
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, DEPTH + 7));
      xact("rand", a, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), {$urandom, $urandom},
           int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
